// File: rtl/classificar_ativo_paralelo_if.sv
// rtl/classificar_ativo_paralelo_if.sv - start/snapshot inputs and result outputs of the classifier
// Optional macro CLASSIFICAR_CONTAGEM_EN adds the active-entry count output.
interface classificar_ativo_paralelo_if #(
    parameter int NUM_NA         = 8,
    parameter int CRITERIO_WIDTH = 5
);
    logic                             aa_atualizar_in;
    logic [NUM_NA-1:0]                na_ativo_in;
    logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in;
    logic                             ca_ocupado_o;
    logic                             ca_pronto_o;
    logic [CRITERIO_WIDTH-1:0]        ca_criterio_geral_out;
    logic [$clog2(NUM_NA)-1:0]        ca_indice_out;
    logic                             ca_vazio_out;
`ifdef CLASSIFICAR_CONTAGEM_EN
    logic [$clog2(NUM_NA+1)-1:0]      ca_num_ativos_out;
`endif

    modport master (
        output aa_atualizar_in, na_ativo_in, na_criterio_in,
        input  ca_ocupado_o, ca_pronto_o, ca_criterio_geral_out, ca_indice_out, ca_vazio_out
`ifdef CLASSIFICAR_CONTAGEM_EN
        , input ca_num_ativos_out
`endif
    );

    modport slave (
        input  aa_atualizar_in, na_ativo_in, na_criterio_in,
        output ca_ocupado_o, ca_pronto_o, ca_criterio_geral_out, ca_indice_out, ca_vazio_out
`ifdef CLASSIFICAR_CONTAGEM_EN
        , output ca_num_ativos_out
`endif
    );
endinterface

// File: rtl/classificar_ativo_paralelo.sv
// rtl/classificar_ativo_paralelo.sv - multi-lane minimum-criterion search over active entries
// Optional macro CLASSIFICAR_CONTAGEM_EN adds ca_num_ativos_out (active entries in the snapshot).
module classificar_ativo_paralelo #(
    parameter int NUM_NA         = 8,
    parameter int CRITERIO_WIDTH = 5,
    parameter int LANES          = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    classificar_ativo_paralelo_if.slave   bus
);
    localparam int CW   = CRITERIO_WIDTH;
    localparam int G    = (NUM_NA + LANES - 1) / LANES;
    localparam int IW   = $clog2(NUM_NA);
    localparam int GW   = $clog2(G + 1);
    localparam int PW   = $clog2(NUM_NA * CW);
    localparam int CNTW = $clog2(NUM_NA + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state_q, state_d;
    logic               start_q;
    logic [GW-1:0]      grupo_q;
    logic [NUM_NA-1:0]  ativo_q;
    logic [NUM_NA*CW-1:0] crit_q;
    logic [CW-1:0]      best_crit_q, run_crit_d;
    logic [IW-1:0]      best_idx_q, run_idx_d;
    logic               found_q, run_found_d;
    logic [CW-1:0]      res_crit_q;
    logic [IW-1:0]      res_idx_q;
    logic               res_vazio_q;
    logic               ultimo_grupo;
    logic               ocupado, pronto;

    assign ultimo_grupo = (grupo_q == GW'(G - 1));

    // Each lane muxes its entry of the current group; lanes are folded in index order
    // so a strict less-than keeps the lower index on ties.
    always_comb begin
        logic          lane_act;
        logic [CW-1:0] lane_crit;
        logic [IW-1:0] lane_idx;
        lane_act    = 1'b0;
        lane_crit   = '0;
        lane_idx    = '0;
        run_crit_d  = best_crit_q;
        run_idx_d   = best_idx_q;
        run_found_d = found_q;
        for (int l = 0; l < LANES; l++) begin
            lane_act  = 1'b0;
            lane_crit = '0;
            lane_idx  = '0;
            for (int gg = 0; gg < G; gg++) begin
                int e;
                int es;
                e  = gg * LANES + l;
                es = (e < NUM_NA) ? e : NUM_NA - 1;
                if (e < NUM_NA && grupo_q == GW'(gg)) begin
                    lane_act  = ativo_q[IW'(es)];
                    lane_crit = crit_q[PW'(CW * es) +: CW];
                    lane_idx  = IW'(es);
                end
            end
            if (lane_act && (!run_found_d || lane_crit < run_crit_d)) begin
                run_found_d = 1'b1;
                run_crit_d  = lane_crit;
                run_idx_d   = lane_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.aa_atualizar_in) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_q) state_d = SCAN;
                SCAN:    if (ultimo_grupo) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ocupado = (state_q == SCAN);
        pronto  = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q     <= 1'b0;
            grupo_q     <= '0;
            ativo_q     <= '0;
            crit_q      <= '0;
            best_crit_q <= '1;
            best_idx_q  <= '0;
            found_q     <= 1'b0;
            res_crit_q  <= '1;
            res_idx_q   <= '0;
            res_vazio_q <= 1'b1;
        end else begin
            start_q <= bus.aa_atualizar_in;
            if (bus.aa_atualizar_in) begin
                ativo_q     <= bus.na_ativo_in;
                crit_q      <= bus.na_criterio_in;
                best_crit_q <= '1;
                best_idx_q  <= '0;
                found_q     <= 1'b0;
                grupo_q     <= '0;
            end else if (state_q == SCAN) begin
                best_crit_q <= run_crit_d;
                best_idx_q  <= run_idx_d;
                found_q     <= run_found_d;
                grupo_q     <= grupo_q + GW'(1);
                if (ultimo_grupo) begin
                    res_crit_q  <= run_found_d ? run_crit_d : '1;
                    res_idx_q   <= run_found_d ? run_idx_d : '0;
                    res_vazio_q <= !run_found_d;
                end
            end
        end
    end

`ifdef CLASSIFICAR_CONTAGEM_EN
    logic [CNTW-1:0] res_num_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_num_q <= '0;
        end else if (!bus.aa_atualizar_in && state_q == SCAN && ultimo_grupo) begin
            res_num_q <= CNTW'($countones(ativo_q));
        end
    end

    assign bus.ca_num_ativos_out = res_num_q;
`endif

    assign bus.ca_ocupado_o          = ocupado;
    assign bus.ca_pronto_o           = pronto;
    assign bus.ca_criterio_geral_out = res_crit_q;
    assign bus.ca_indice_out         = res_idx_q;
    assign bus.ca_vazio_out          = res_vazio_q;
endmodule

// File: tb/tb_classificar_ativo_paralelo.sv
// tb/tb_classificar_ativo_paralelo.sv - directed bench for the classifier with LANES=2 and LANES=3 instances
module tb_classificar_ativo_paralelo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    classificar_ativo_paralelo_if #(.NUM_NA(8), .CRITERIO_WIDTH(5)) bus2 ();
    classificar_ativo_paralelo_if #(.NUM_NA(8), .CRITERIO_WIDTH(5)) bus3 ();

    classificar_ativo_paralelo #(.NUM_NA(8), .CRITERIO_WIDTH(5), .LANES(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    classificar_ativo_paralelo #(.NUM_NA(8), .CRITERIO_WIDTH(5), .LANES(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic [7:0] a, input logic [39:0] c);
        bus2.na_ativo_in    = a;
        bus2.na_criterio_in = c;
        bus3.na_ativo_in    = a;
        bus3.na_criterio_in = c;
    endtask

    task automatic do_start(input logic [7:0] a, input logic [39:0] c);
        set_inputs(a, c);
        bus2.aa_atualizar_in = 1'b1;
        bus3.aa_atualizar_in = 1'b1;
        tick();
        bus2.aa_atualizar_in = 1'b0;
        bus3.aa_atualizar_in = 1'b0;
    endtask

    // Called just after the start edge; LANES=2 pronto after 5 edges, LANES=3 after 4.
    task automatic run_scan(input bit chg);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (chg && k == 2) set_inputs(8'hFF, 40'd0);
            chk($sformatf("pronto2_k%0d", k), bus2.ca_pronto_o, 32'(k == 5));
            chk($sformatf("ocupado2_k%0d", k), bus2.ca_ocupado_o, 32'(k <= 4));
            chk($sformatf("pronto3_k%0d", k), bus3.ca_pronto_o, 32'(k == 4));
            chk($sformatf("ocupado3_k%0d", k), bus3.ca_ocupado_o, 32'(k <= 3));
        end
    endtask

    task automatic chk_res(input string tag, input int crit, input int idx, input int vazio);
        chk({tag, "_crit2"}, bus2.ca_criterio_geral_out, crit);
        chk({tag, "_idx2"}, bus2.ca_indice_out, idx);
        chk({tag, "_vazio2"}, bus2.ca_vazio_out, vazio);
        chk({tag, "_crit3"}, bus3.ca_criterio_geral_out, crit);
        chk({tag, "_idx3"}, bus3.ca_indice_out, idx);
        chk({tag, "_vazio3"}, bus3.ca_vazio_out, vazio);
    endtask

    initial begin
        bus2.aa_atualizar_in = 1'b0;
        bus3.aa_atualizar_in = 1'b0;
        set_inputs(8'h00, 40'd0);
        tick();
        tick();
        chk("rst_ocupado", bus2.ca_ocupado_o, 0);
        chk("rst_pronto", bus2.ca_pronto_o, 0);
        chk_res("rst", 31, 0, 1);
`ifdef CLASSIFICAR_CONTAGEM_EN
        chk("rst_num", bus2.ca_num_ativos_out, 0);
`endif
        rst = 1'b0;
        tick();

        // all active, criteria {9,7,12,3,20,3,15,31}: tie at 3 resolves to index 3
        do_start(8'hFF, {5'd31, 5'd15, 5'd3, 5'd20, 5'd3, 5'd12, 5'd7, 5'd9});
        chk_res("hold_before", 31, 0, 1);
        run_scan(1'b0);
        chk_res("full", 3, 3, 0);
`ifdef CLASSIFICAR_CONTAGEM_EN
        chk("full_num", bus2.ca_num_ativos_out, 8);
`endif

        // none active
        do_start(8'h00, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8});
        tick();
        chk_res("hold_mid", 3, 3, 0);
        for (int k = 2; k <= 5; k++) tick();
        chk("empty_pronto", bus2.ca_pronto_o, 1);
        chk_res("empty", 31, 0, 1);
`ifdef CLASSIFICAR_CONTAGEM_EN
        chk("empty_num", bus2.ca_num_ativos_out, 0);
`endif
        tick();

        // only entry 7 active with all-ones criterion
        do_start(8'h80, {5'd31, 35'd0});
        run_scan(1'b0);
        chk_res("last", 31, 7, 0);
`ifdef CLASSIFICAR_CONTAGEM_EN
        chk("last_num", bus2.ca_num_ativos_out, 1);
`endif

        // inputs change after the start cycle: snapshot result {10,4,6,8} -> 4 at index 1
        do_start(8'h0F, {20'd0, 5'd8, 5'd6, 5'd4, 5'd10});
        run_scan(1'b1);
        chk_res("snapshot", 4, 1, 0);

        // restart one cycle into a scan: only the second scan reports
        do_start(8'h0F, {20'd0, 5'd8, 5'd6, 5'd4, 5'd10});
        tick();
        do_start(8'h30, {10'd0, 5'd1, 5'd2, 20'd0});
        run_scan(1'b0);
        chk_res("restart", 1, 5, 0);

        // reset during a scan discards it
        do_start(8'hFF, {5'd31, 5'd15, 5'd3, 5'd20, 5'd3, 5'd12, 5'd7, 5'd9});
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ocupado", bus2.ca_ocupado_o, 0);
        chk_res("midrst", 31, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("midrst_pronto2_k%0d", k), bus2.ca_pronto_o, 0);
            chk($sformatf("midrst_pronto3_k%0d", k), bus3.ca_pronto_o, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/classificar_ativo_paralelo.md
CLASSIFICAR_ATIVO_PARALELO -- requirements
Module: classificar_ativo_paralelo

Interface
REQ-001 SHALL have parameter NUM_NA, default 8: number of node entries (>=2).
REQ-002 SHALL have parameter CRITERIO_WIDTH, default 5: bits per criterion.
REQ-003 SHALL have parameter LANES, default 2: entries compared per cycle (1..NUM_NA); G = ceil(NUM_NA/LANES) groups.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port aa_atualizar_in, input, 1: start pulse; samples inputs.
REQ-007 SHALL have port na_ativo_in, input, NUM_NA: per-entry active flag.
REQ-008 SHALL have port na_criterio_in, input, NUM_NA*CRITERIO_WIDTH: entry i at bits [CRITERIO_WIDTH*i +: CRITERIO_WIDTH].
REQ-009 SHALL have port ca_ocupado_o, output, 1: scan in progress.
REQ-010 SHALL have port ca_pronto_o, output, 1: one-cycle result-valid pulse.
REQ-011 SHALL have port ca_criterio_geral_out, output, CRITERIO_WIDTH: minimum active criterion.
REQ-012 SHALL have port ca_indice_out, output, $clog2(NUM_NA): index of winning entry.
REQ-013 SHALL have port ca_vazio_out, output, 1: no entry was active.

Function
REQ-014 States SHALL be IDLE, SCAN, DONE; reset enters IDLE.
REQ-015 aa_atualizar_in=1 in any state SHALL snapshot na_ativo_in and na_criterio_in into internal registers, clear the running result, zero the group counter and enter SCAN next cycle.
REQ-016 Start during SCAN or DONE SHALL abort the current scan without asserting ca_pronto_o for it.
REQ-017 In SCAN, each cycle SHALL evaluate snapshot entries g*LANES..g*LANES+LANES-1 of group g (g=0..G-1); indices >= NUM_NA SHALL be treated as inactive.
REQ-018 The running best SHALL be replaced only by an active entry with strictly smaller criterion, or by the first active entry seen; on equal criteria the lower index SHALL win.
REQ-019 An active entry with criterion all-ones SHALL be a valid winner (ca_vazio_out=0).
REQ-020 After group G-1 the FSM SHALL enter DONE for exactly one cycle, asserting ca_pronto_o, then return to IDLE.
REQ-021 Latency: start sampled at edge 0 -> ca_ocupado_o high edges 1..G -> ca_pronto_o high after edge G+1.
REQ-022 ca_criterio_geral_out, ca_indice_out, ca_vazio_out SHALL update only when ca_pronto_o asserts and hold until the next ca_pronto_o.
REQ-023 With no active entry: criterio all-ones, indice 0, vazio 1.
REQ-024 Input changes after the start cycle SHALL NOT affect the result.
REQ-025 Group counter width SHALL be $clog2(G+1); no wrap occurs inside a scan.

Reset
REQ-026 rst=1 SHALL force IDLE; ca_ocupado_o=0, ca_pronto_o=0, ca_criterio_geral_out=all-ones, ca_indice_out=0, ca_vazio_out=1, counter=0.
REQ-027 rst SHALL take priority over aa_atualizar_in; reset mid-scan SHALL discard it with no ca_pronto_o.

Configuration
REQ-028 Macro CLASSIFICAR_CONTAGEM_EN defined: extra output ca_num_ativos_out, width $clog2(NUM_NA+1), = number of active snapshot entries, updated with ca_pronto_o, reset 0.
REQ-029 Macro CLASSIFICAR_CONTAGEM_EN undefined: port and counting logic absent; all other behaviour identical.

Verification (NUM_NA=8, CRITERIO_WIDTH=5, LANES=2, G=4)
REQ-030 ativo=8'hFF, criteria i=0..7 {9,7,12,3,20,3,15,31}, start -> pronto exactly 5 cycles after start edge; criterio=3, indice=3, vazio=0.
REQ-031 ativo=8'h00 -> pronto after 5 cycles; criterio=31, indice=0, vazio=1; with CLASSIFICAR_CONTAGEM_EN num_ativos=0.
REQ-032 ativo=8'h80, criterion7=31 -> criterio=31, indice=7, vazio=0; with CLASSIFICAR_CONTAGEM_EN num_ativos=1.
REQ-033 Start, change inputs at cycle 2 -> result reflects cycle-0 snapshot; restart at cycle 2 -> no pronto until 5 cycles after second start.
REQ-034 rst pulsed at cycle 3 of scan -> no pronto, outputs return to reset values; LANES=3 (G=3) rerun of REQ-030 -> same result, pronto after 4 cycles.
